// File: rtl/amp_pwr_seq.sv
// ============================================================================
// Module   : amp_pwr_seq
// Brief    : Class-D amplifier power-up / fault-retry / lockout sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module amp_pwr_seq #(
  parameter int SHTDWN_CYC = 250000,
  parameter int UNMUTE_SMP = 16,
  parameter int RETRY_CYC  = 2500000,
  parameter int CLEAN_SMP  = 48000,
  parameter int MAX_FLT    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Flt_n,
  input  logic       vld,
  input  logic       clr_lock,
  output logic       sht_dwn,
  output logic       mute,
  output logic [2:0] fault_cnt,
  output logic       lockout
);

  localparam int c_MAX_A   = (SHTDWN_CYC > RETRY_CYC) ? SHTDWN_CYC : RETRY_CYC;
  localparam int c_MAX_CNT = (c_MAX_A > CLEAN_SMP) ? c_MAX_A : CLEAN_SMP;
  localparam int c_CW      = $clog2(c_MAX_CNT + 1);

  localparam logic [c_CW-1:0] c_SHT_LAST = c_CW'(SHTDWN_CYC - 1);
  localparam logic [c_CW-1:0] c_UNM_LAST = c_CW'(UNMUTE_SMP - 1);
  localparam logic [c_CW-1:0] c_RTY_LAST = c_CW'(RETRY_CYC - 1);
  localparam logic [c_CW-1:0] c_CLN_LAST = c_CW'(CLEAN_SMP - 1);

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_UNMUTE   = 3'd1,
    ST_RUN      = 3'd2,
    ST_FAULT    = 3'd3,
    ST_LOCK     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic [2:0]        r_fault_cnt;
  logic [2:0]        w_fault_cnt_nxt;
  logic [2:0]        w_fc_inc;
  logic              w_lock_hit;
  logic [1:0]        r_sync;
  logic              w_flt;
  logic              r_sht_dwn;
  logic              r_mute;
  logic              r_lockout;

  // Synchronizer idles at 1 so reset release never looks like a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], Flt_n};
  end

  assign w_flt      = ~r_sync[1];
  assign w_fc_inc   = (r_fault_cnt == 3'd7) ? 3'd7 : r_fault_cnt + 3'd1;
  assign w_lock_hit = (32'(w_fc_inc) >= MAX_FLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SHUTDOWN;
      r_cnt       <= '0;
      r_fault_cnt <= 3'd0;
      r_sht_dwn   <= 1'b1;
      r_mute      <= 1'b1;
      r_lockout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fault_cnt <= w_fault_cnt_nxt;
      r_sht_dwn   <= (w_state_nxt != ST_UNMUTE) && (w_state_nxt != ST_RUN);
      r_mute      <= (w_state_nxt != ST_RUN);
      r_lockout   <= (w_state_nxt == ST_LOCK);
    end
  end

  // Fault is tested before any terminal count so it always wins a tie.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_fault_cnt_nxt = r_fault_cnt;
    case (r_state)
      ST_SHUTDOWN: begin
        if (r_cnt >= c_SHT_LAST) begin
          w_state_nxt = ST_UNMUTE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      ST_UNMUTE, ST_RUN: begin
        if (w_flt) begin
          w_fault_cnt_nxt = w_fc_inc;
          w_state_nxt     = w_lock_hit ? ST_LOCK : ST_FAULT;
          w_cnt_nxt       = '0;
        end else if (vld) begin
          if (r_state == ST_UNMUTE && r_cnt >= c_UNM_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else if (r_state == ST_RUN && r_cnt >= c_CLN_LAST) begin
            w_fault_cnt_nxt = 3'd0;
            w_cnt_nxt       = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CW'(1);
          end
        end
      end
      ST_FAULT: begin
        // Counter parks at the retry threshold while the fault persists.
        if (r_cnt >= c_RTY_LAST) begin
          if (!w_flt) begin
            w_state_nxt = ST_SHUTDOWN;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      ST_LOCK: begin
        if (clr_lock) begin
          w_state_nxt     = ST_SHUTDOWN;
          w_cnt_nxt       = '0;
          w_fault_cnt_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_SHUTDOWN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sht_dwn   = r_sht_dwn;
  assign mute      = r_mute;
  assign fault_cnt = r_fault_cnt;
  assign lockout   = r_lockout;

endmodule

`default_nettype wire

// File: tb/tb_amp_pwr_seq.sv
// ============================================================================
// Module   : tb_amp_pwr_seq
// Brief    : Scoreboard bench for amp_pwr_seq (small parameter set).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_amp_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Flt_n;
  logic       vld;
  logic       clr_lock;
  logic       sht_dwn;
  logic       mute;
  logic [2:0] fault_cnt;
  logic       lockout;

  amp_pwr_seq #(
    .SHTDWN_CYC (20),
    .UNMUTE_SMP (4),
    .RETRY_CYC  (30),
    .CLEAN_SMP  (8),
    .MAX_FLT    (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Flt_n     (Flt_n),
    .vld       (vld),
    .clr_lock  (clr_lock),
    .sht_dwn   (sht_dwn),
    .mute      (mute),
    .fault_cnt (fault_cnt),
    .lockout   (lockout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic       sd;
    logic       mu;
    logic [2:0] fc;
    logic       lk;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_at(input int k, input string name, input logic sd,
                           input logic mu, input logic [2:0] fc, input logic lk);
    exp_t e;
    int   idx;
    e.at = cyc + k; e.name = name; e.sd = sd; e.mu = mu; e.fc = fc; e.lk = lk;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].at > e.at) idx--;
    sb.insert(idx, e);
  endtask

  // Monitor: compares every expectation due at this cycle's negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e_mon = sb.pop_front();
      checks++;
      if (e_mon.at != cyc || sht_dwn !== e_mon.sd || mute !== e_mon.mu ||
          fault_cnt !== e_mon.fc || lockout !== e_mon.lk) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): got sd=%b mu=%b fc=%0d lk=%b, expected sd=%b mu=%b fc=%0d lk=%b",
                 e_mon.name, cyc, e_mon.at, sht_dwn, mute, fault_cnt, lockout,
                 e_mon.sd, e_mon.mu, e_mon.fc, e_mon.lk);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One audio strobe, spaced 5 clk; the strobe is registered on return.
  task automatic strobe();
    repeat (4) step();
    vld = 1'b1;
    step();
    vld = 1'b0;
  endtask

  task automatic release_and_power_up(input string tag, input logic [2:0] fc);
    rst_n = 1'b1;
    expect_at(19, {tag, "_hold_last"}, 1'b1, 1'b1, fc, 1'b0);
    expect_at(20, {tag, "_sht_fall"},  1'b0, 1'b1, fc, 1'b0);
    repeat (20) step();
  endtask

  task automatic unmute_to_run(input string tag, input logic [2:0] fc);
    for (int i = 1; i <= 4; i++) begin
      strobe();
      expect_at(0, {tag, "_unmute_vld"}, 1'b0, (i < 4), fc, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; Flt_n = 1'b1; vld = 1'b0; clr_lock = 1'b0;
    repeat (3) step();
    expect_at(0, "reset_state", 1'b1, 1'b1, 3'd0, 1'b0);
    step();

    // Clean power-up
    release_and_power_up("pu0", 3'd0);
    unmute_to_run("pu0", 3'd0);

    // Long fault in RUN: 50 clk low
    Flt_n = 1'b0;
    expect_at(2,  "flt_not_yet",    1'b0, 1'b0, 3'd0, 1'b0);
    expect_at(3,  "flt_3clk",       1'b1, 1'b1, 3'd1, 1'b0);
    expect_at(72, "retry_hold",     1'b1, 1'b1, 3'd1, 1'b0);
    expect_at(73, "retry_sht_fall", 1'b0, 1'b1, 3'd1, 1'b0);
    repeat (50) step();
    Flt_n = 1'b1;
    repeat (23) step();
    unmute_to_run("pu1", 3'd1);

    // Eight clean samples clear the count
    for (int i = 1; i <= 8; i++) begin
      strobe();
      expect_at(0, "clean_smp", 1'b0, 1'b0, (i < 8) ? 3'd1 : 3'd0, 1'b0);
    end

    // Short fault: minimum retry time, then a glitch during SHUTDOWN is ignored
    Flt_n = 1'b0;
    expect_at(3,  "short_flt",      1'b1, 1'b1, 3'd1, 1'b0);
    expect_at(52, "sd_glitch_hold", 1'b1, 1'b1, 3'd1, 1'b0);
    expect_at(53, "sd_glitch_fall", 1'b0, 1'b1, 3'd1, 1'b0);
    repeat (5) step();
    Flt_n = 1'b1;
    repeat (31) step();
    Flt_n = 1'b0;
    repeat (5) step();
    Flt_n = 1'b1;
    repeat (12) step();

    // Fault coinciding with the 4th UNMUTE strobe
    for (int i = 1; i <= 3; i++) begin
      strobe();
      expect_at(0, "tie_pre_vld", 1'b0, 1'b1, 3'd1, 1'b0);
    end
    repeat (2) step();
    Flt_n = 1'b0;
    step();
    step();
    vld = 1'b1;
    step();
    vld = 1'b0;
    expect_at(0,  "tie_fault_wins", 1'b1, 1'b1, 3'd2, 1'b0);
    Flt_n = 1'b1;
    expect_at(49, "tie_retry_hold", 1'b1, 1'b1, 3'd2, 1'b0);
    expect_at(50, "tie_retry_fall", 1'b0, 1'b1, 3'd2, 1'b0);
    repeat (50) step();
    unmute_to_run("pu2", 3'd2);

    // clr_lock outside LOCK has no effect
    clr_lock = 1'b1;
    step();
    clr_lock = 1'b0;
    expect_at(0, "clr_ignored", 1'b0, 1'b0, 3'd2, 1'b0);

    // Third fault -> FAULT, fourth fault -> LOCK
    Flt_n = 1'b0;
    expect_at(3,  "flt3",      1'b1, 1'b1, 3'd3, 1'b0);
    expect_at(53, "flt3_fall", 1'b0, 1'b1, 3'd3, 1'b0);
    repeat (5) step();
    Flt_n = 1'b1;
    repeat (48) step();
    unmute_to_run("pu3", 3'd3);
    Flt_n = 1'b0;
    expect_at(3, "lock_enter", 1'b1, 1'b1, 3'd4, 1'b1);
    repeat (40) step();
    Flt_n = 1'b1;
    repeat (10) step();
    expect_at(0,  "lock_held",    1'b1, 1'b1, 3'd4, 1'b1);
    expect_at(1,  "lock_cleared", 1'b1, 1'b1, 3'd0, 1'b0);
    expect_at(20, "clr_pu_hold",  1'b1, 1'b1, 3'd0, 1'b0);
    expect_at(21, "clr_pu_fall",  1'b0, 1'b1, 3'd0, 1'b0);
    clr_lock = 1'b1;
    step();
    clr_lock = 1'b0;
    repeat (20) step();

    // Reset mid-FAULT count is immediate
    Flt_n = 1'b0;
    expect_at(3, "rst_pre_flt", 1'b1, 1'b1, 3'd1, 1'b0);
    repeat (10) step();
    rst_n = 1'b0;
    Flt_n = 1'b1;
    expect_at(0, "async_reset", 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    step();
    release_and_power_up("pu4", 3'd0);
    unmute_to_run("pu4", 3'd0);

    repeat (5) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
